// File: rtl/rr_arb_4to1_if.sv
// Bundle between four producers, the round-robin arbiter and one downstream consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface rr_arb_4to1_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          req_i;
  logic [4*DATA_W-1:0] data_i;
  logic                ready_i;
  logic                valid_o;
  logic [DATA_W-1:0]   data_o;
  logic [1:0]          sel_o;
  logic [3:0]          ack_o;
  logic                busy_o;

  modport slave (
    input  req_i, data_i, ready_i,
    output valid_o, data_o, sel_o, ack_o, busy_o
  );

  modport master (
    output req_i, data_i, ready_i,
    input  valid_o, data_o, sel_o, ack_o, busy_o
  );
endinterface

// File: rtl/rr_arb_4to1.sv
// Round-robin 4:1 channel arbiter with bounded bursts; the winner holds the channel for up to
// MAX_BURST accepted beats, then a one-cycle idle bubble precedes re-arbitration.
module rr_arb_4to1 #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rr_arb_4to1_if.slave     bus
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_last;
  logic [CntW-1:0]   r_beat_cnt;

  logic [1:0]        w_win;
  logic              w_busy;
  logic              w_valid;
  logic              w_beat;

  // Scan from furthest offset down so the nearest requester after r_last wins.
  always_comb begin
    w_win = r_last;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req_i[r_last + 2'(i + 1)]) begin
        w_win = r_last + 2'(i + 1);
      end
    end
  end

  assign w_busy  = (r_state == StBusy);
  assign w_valid = w_busy & bus.req_i[r_sel];
  assign w_beat  = w_valid & bus.ready_i;

  assign bus.valid_o = w_valid;
  assign bus.data_o  = bus.data_i[r_sel*DATA_W +: DATA_W];
  assign bus.sel_o   = r_sel;
  assign bus.ack_o   = w_beat ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.busy_o  = w_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_sel      <= 2'd0;
      r_last     <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|bus.req_i) begin
            r_sel      <= w_win;
            r_last     <= w_win;
            r_beat_cnt <= '0;
            r_state    <= StBusy;
          end
        end
        StBusy: begin
          if (!bus.req_i[r_sel]) begin
            r_state <= StIdle;
          end else if (bus.ready_i) begin
            if (r_beat_cnt == CntW'(MAX_BURST - 1)) begin
              r_beat_cnt <= '0;
              r_state    <= StIdle;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for rr_arb_4to1: a MAX_BURST=4 instance plus a MAX_BURST=1 instance
// sharing the same inputs.
module tb_rr_arb_4to1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rr_arb_4to1_if #(.DATA_W(8)) bus  ();
  rr_arb_4to1_if #(.DATA_W(8)) bus1 ();

  assign bus1.req_i   = bus.req_i;
  assign bus1.data_i  = bus.data_i;
  assign bus1.ready_i = bus.ready_i;

  rr_arb_4to1 #(.DATA_W(8), .MAX_BURST(4)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  rr_arb_4to1 #(.DATA_W(8), .MAX_BURST(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, drive req/ready, release after a posedge; the next posedge is the first grant.
  task automatic do_reset(input logic [3:0] req, input logic rdy);
    rst_n       = 1'b0;
    bus.req_i   = req;
    bus.ready_i = rdy;
    step();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_ack;
    bus.req_i   = 4'b1111;
    bus.ready_i = 1'b1;
    bus.data_i  = 32'hD3_A5_B2_C1;

    // Reset state while all requesters are asserted
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
    check_eq("rst_ack",   32'(bus.ack_o),   32'd0);
    check_eq("rst_sel",   32'(bus.sel_o),   32'd0);
    check_eq("rst_busy",  32'(bus.busy_o),  32'd0);
    check_eq("rst_data",  32'(bus.data_o),  32'hC1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_idle", 32'(bus.busy_o), 32'd0);

    // Saturated round robin: 4 beats per grant then one bubble (MAX_BURST=1: 1 beat + bubble)
    for (int k = 0; k < 24; k++) begin
      step();
      @(negedge clk);
      exp_ack = (k % 5 == 4) ? 4'b0000 : (4'b0001 << ((k / 5) % 4));
      check_eq($sformatf("rr_ack[%0d]", k),  32'(bus.ack_o),  32'(exp_ack));
      check_eq($sformatf("rr_busy[%0d]", k), 32'(bus.busy_o), 32'(k % 5 != 4));
      exp_ack = (k % 2 == 1) ? 4'b0000 : (4'b0001 << ((k / 2) % 4));
      check_eq($sformatf("mb1_ack[%0d]", k), 32'(bus1.ack_o), 32'(exp_ack));
      if (k == 0) begin
        check_eq("rr_first_sel",   32'(bus.sel_o),   32'd0);
        check_eq("rr_first_valid", 32'(bus.valid_o), 32'd1);
      end
    end

    // Single requester 2: four beats, bubble, regrant
    do_reset(4'b0100, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      if (k == 4) begin
        check_eq("single_bubble_busy", 32'(bus.busy_o), 32'd0);
        check_eq("single_bubble_ack",  32'(bus.ack_o),  32'd0);
      end else begin
        check_eq($sformatf("single_sel[%0d]", k),  32'(bus.sel_o),  32'd2);
        check_eq($sformatf("single_data[%0d]", k), 32'(bus.data_o), 32'hA5);
        check_eq($sformatf("single_ack[%0d]", k),  32'(bus.ack_o),  32'h4);
      end
    end

    // Stall on requester 1; data_o follows data_i while held
    do_reset(4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 2) bus.data_i[15:8] = 8'h5E;
      @(negedge clk);
      check_eq($sformatf("stall_valid[%0d]", k), 32'(bus.valid_o), 32'd1);
      check_eq($sformatf("stall_ack[%0d]", k),   32'(bus.ack_o),   32'd0);
      check_eq($sformatf("stall_sel[%0d]", k),   32'(bus.sel_o),   32'd1);
      check_eq($sformatf("stall_data[%0d]", k),  32'(bus.data_o), (k < 2) ? 32'hB2 : 32'h5E);
    end
    // Beat count untouched by the stall: four full beats still available
    for (int k = 0; k < 5; k++) begin
      step();
      bus.ready_i = 1'b1;
      @(negedge clk);
      check_eq($sformatf("unstall_ack[%0d]", k), 32'(bus.ack_o), (k < 4) ? 32'h2 : 32'h0);
    end

    // Withdraw: requester 3 drops after 2 beats, requester 0 then wins
    do_reset(4'b1000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      check_eq($sformatf("wd_ack[%0d]", k), 32'(bus.ack_o), 32'h8);
      check_eq($sformatf("wd_sel[%0d]", k), 32'(bus.sel_o), 32'd3);
    end
    step();
    bus.req_i = 4'b0001;
    @(negedge clk);
    check_eq("wd_drop_valid", 32'(bus.valid_o), 32'd0);
    check_eq("wd_drop_ack",   32'(bus.ack_o),   32'd0);
    check_eq("wd_drop_busy",  32'(bus.busy_o),  32'd1);
    step();
    @(negedge clk);
    check_eq("wd_idle_busy", 32'(bus.busy_o), 32'd0);
    step();
    @(negedge clk);
    check_eq("wd_next_sel", 32'(bus.sel_o), 32'd0);
    check_eq("wd_next_ack", 32'(bus.ack_o), 32'h1);
    step();
    @(negedge clk);
    check_eq("mid_pre_ack", 32'(bus.ack_o), 32'h1);

    // Asynchronous reset mid-burst
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ack",   32'(bus.ack_o),   32'd0);
    check_eq("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check_eq("mid_rst_busy",  32'(bus.busy_o),  32'd0);
    check_eq("mid_rst_sel",   32'(bus.sel_o),   32'd0);
    bus.req_i = 4'b0110;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check_eq("post_rst_sel", 32'(bus.sel_o), 32'd1);
    check_eq("post_rst_ack", 32'(bus.ack_o), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
